// File: rtl/pow_trit_pkg.sv
// ============================================================================
//  Module      : pow_trit_pkg
//  Description : Shared trit encoding, word geometry, decoder FSM states and a
//                per-trit decode helper for the PoW trit datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pow_trit_pkg;

    // Two-bit trit codes used throughout the PoW datapath
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_ILL  = 2'b10;

    localparam int TRIT_W     = 2;
    localparam int NUM_TRITS  = 27;
    localparam int TRIT_VEC_W = NUM_TRITS * TRIT_W;   // 54

    // Decoder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } dec_state_t;

    // Decoded trit: signed digit plus illegal-code marker
    typedef struct packed {
        logic signed [1:0] val;
        logic              ill;
    } trit_dec_t;

    // Map a 2-bit code to its balanced-ternary digit; the illegal code reads
    // as zero so the arithmetic stays well defined while the flag is raised.
    function automatic trit_dec_t trit_to_signed(input logic [1:0] code);
        trit_dec_t d;
        d.val = 2'sd0;
        d.ill = 1'b0;
        case (code)
            TRIT_POS: d.val = 2'sd1;
            TRIT_NEG: d.val = -2'sd1;
            TRIT_ILL: d.ill = 1'b1;
            default:  d.val = 2'sd0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trit_horner_step.sv
// ============================================================================
//  Module      : trit_horner_step
//  Description : Combinational Horner fold of TRITS_PER_CYCLE trits into a
//                signed accumulator, most significant trit first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trit_horner_step
    import pow_trit_pkg::*;
#(
    parameter int TRITS_PER_CYCLE = 1,
    parameter int OUT_W           = 43
) (
    input  logic signed [OUT_W-1:0]             i_acc,
    input  logic        [2*TRITS_PER_CYCLE-1:0] i_trits,   // MS trit in top bits
    output logic signed [OUT_W-1:0]             o_acc,
    output logic                                o_ill
);

    logic signed [OUT_W-1:0] w_acc;
    logic                    w_ill;
    trit_dec_t               w_dec;

    // Chain acc = acc*3 + t across the slice; acc*3 formed as (acc<<1)+acc
    always_comb begin
        w_acc = i_acc;
        w_ill = 1'b0;
        w_dec = '0;
        for (int k = TRITS_PER_CYCLE - 1; k >= 0; k--) begin
            w_dec = trit_to_signed(i_trits[2*k +: 2]);
            w_acc = (w_acc <<< 1) + w_acc + {{(OUT_W-2){w_dec.val[1]}}, w_dec.val};
            w_ill = w_ill | w_dec.ill;
        end
        o_acc = w_acc;
        o_ill = w_ill;
    end

endmodule

`default_nettype wire

// File: rtl/trit_vec_decoder.sv
// ============================================================================
//  Module      : trit_vec_decoder
//  Description : Converts one 27-trit balanced-ternary word into a signed
//                two's-complement integer by multi-cycle Horner evaluation,
//                with valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trit_vec_decoder
    import pow_trit_pkg::*;
#(
    parameter int TRITS_PER_CYCLE = 1,
    parameter int NUM_TRITS       = 27,
    parameter int OUT_W           = 43
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [TRIT_VEC_W-1:0]   i_trits,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic signed [OUT_W-1:0] o_value,
    output logic                    o_err,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int C_STEP_W = 2 * TRITS_PER_CYCLE;
    localparam int C_NCYC   = 27 / TRITS_PER_CYCLE;
    localparam int C_CNT_W  = (C_NCYC > 1) ? $clog2(C_NCYC) : 1;

    // Reject configurations the datapath was not built for
    generate
        if (!(TRITS_PER_CYCLE == 1 || TRITS_PER_CYCLE == 3 ||
              TRITS_PER_CYCLE == 9 || TRITS_PER_CYCLE == 27)) begin : g_bad_tpc
            $error("trit_vec_decoder: TRITS_PER_CYCLE must be 1, 3, 9 or 27");
        end
        if (NUM_TRITS != 27) begin : g_bad_num_trits
            $error("trit_vec_decoder: NUM_TRITS must be 27");
        end
        if (OUT_W < 43) begin : g_bad_out_w
            $error("trit_vec_decoder: OUT_W must be at least 43");
        end
    endgenerate

    dec_state_t                r_state;
    dec_state_t                w_state_nxt;
    logic [TRIT_VEC_W-1:0]     r_shift;
    logic signed [OUT_W-1:0]   r_acc;
    logic                      r_ill;
    logic [C_CNT_W-1:0]        r_cnt;
    logic signed [OUT_W-1:0]   r_value;
    logic                      r_err;
    logic                      r_valid;

    logic signed [OUT_W-1:0]   w_step_acc;
    logic                      w_step_ill;
    logic                      w_fire_in;
    logic                      w_last;
    logic                      w_fire_out;

    // Single Horner stage reused on every CONV cycle
    trit_horner_step #(
        .TRITS_PER_CYCLE (TRITS_PER_CYCLE),
        .OUT_W           (OUT_W)
    ) u_step (
        .i_acc   (r_acc),
        .i_trits (r_shift[TRIT_VEC_W-1 -: C_STEP_W]),
        .o_acc   (w_step_acc),
        .o_ill   (w_step_ill)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; o_ready depends only on state
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        w_fire_in   = 1'b0;
        w_last      = 1'b0;
        w_fire_out  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready   = 1'b1;
                w_fire_in = i_valid;
                if (i_valid) begin
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                w_last = (r_cnt == C_CNT_W'(C_NCYC - 1));
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_fire_out = i_ready;
                if (i_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Conversion datapath: capture, fold-and-shift, trit counter
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_fire_in) begin
            r_shift <= i_trits;
            r_acc   <= '0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_CONV) begin
            r_shift <= r_shift << C_STEP_W;
            r_acc   <= w_step_acc;
            r_ill   <= r_ill | w_step_ill;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Output register: loads on the final fold, holds until the handshake
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_value <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_last) begin
            r_value <= w_step_acc;
            r_err   <= r_ill | w_step_ill;
            r_valid <= 1'b1;
        end else if (w_fire_out) begin
            r_valid <= 1'b0;
        end
    end

    assign o_value = r_value;
    assign o_err   = r_err;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_trit_vec_decoder.sv
// ============================================================================
//  Module      : tb_trit_vec_decoder
//  Description : Scoreboard bench for trit_vec_decoder at TRITS_PER_CYCLE of
//                1, 3 and 27, using directed words with hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trit_vec_decoder;

    localparam int OUT_W = 43;

    typedef struct {
        int                      idx;
        logic signed [OUT_W-1:0] v;
        logic                    e;
    } exp_t;

    logic                    clk;
    logic                    arst;
    logic [53:0]             trits [3];
    logic [2:0]              vld;
    logic [2:0]              rdy_in;
    wire  [2:0]              o_rdy;
    wire  [2:0]              o_vld;
    wire  [2:0]              o_err;
    wire  signed [OUT_W-1:0] o_val [3];

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three decoders differing only in fold width
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            trit_vec_decoder #(
                .TRITS_PER_CYCLE ((g == 0) ? 1 : (g == 1) ? 3 : 27),
                .NUM_TRITS       (27),
                .OUT_W           (OUT_W)
            ) u_dut (
                .i_clk   (clk),
                .i_arst  (arst),
                .i_trits (trits[g]),
                .i_valid (vld[g]),
                .o_ready (o_rdy[g]),
                .o_value (o_val[g]),
                .o_err   (o_err[g]),
                .o_valid (o_vld[g]),
                .i_ready (rdy_in[g])
            );
        end
    endgenerate

    function automatic int ncyc(int idx);
        return (idx == 0) ? 27 : (idx == 1) ? 9 : 1;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever an output handshake is pending
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!arst && o_vld[i] && rdy_in[i]) begin
                if (q.size() == 0) begin
                    chk("unexpected output", i, -1);
                end else begin
                    e = q.pop_front();
                    chk("output dut index", i, e.idx);
                    chk("o_value", o_val[i], e.v);
                    chk("o_err", o_err[i], e.e);
                end
            end
        end
    end

    // Issue one word; latency counts posedges after the capture edge until
    // o_valid, which is 27/TPC (o_valid high in cycle N + 27/TPC + 1).
    task automatic send(int idx, logic [53:0] w, longint ev, bit ee, bit scramble, int stall);
        exp_t   e;
        int     cnt;
        longint held;
        e.idx = idx;
        e.v   = OUT_W'(ev);
        e.e   = ee;
        q.push_back(e);
        trits[idx] = w;
        vld[idx]   = 1'b1;
        @(negedge clk);
        chk("o_ready in IDLE", o_rdy[idx], 1);
        @(posedge clk); #1;
        if (scramble) trits[idx] = ~w;   // must be ignored outside IDLE
        else          vld[idx]   = 1'b0;
        cnt = 0;
        while (!o_vld[idx] && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        vld[idx] = 1'b0;
        chk("latency", cnt, ncyc(idx));
        held = o_val[idx];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall o_valid", o_vld[idx], 1);
            chk("stall o_ready", o_rdy[idx], 0);
            chk("stall o_value", o_val[idx], held);
        end
        @(posedge clk); #1;
        rdy_in[idx] = 1'b1;
        @(posedge clk); #1;
        rdy_in[idx] = 1'b0;
        chk("o_valid after handshake", o_vld[idx], 0);
        chk("o_ready after handshake", o_rdy[idx], 1);
    endtask

    // Capture a word, then hit reset in the fifth CONV cycle
    task automatic abort_conv(int idx, logic [53:0] w);
        trits[idx] = w;
        vld[idx]   = 1'b1;
        @(posedge clk); #1;
        vld[idx] = 1'b0;
        repeat (4) @(posedge clk);
        #1 arst = 1'b1;
        #1;
        chk("abort o_valid", o_vld[idx], 0);
        chk("abort o_ready", o_rdy[idx], 1);
        chk("abort o_value", o_val[idx], 0);
        #2 arst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int wait_cnt;
        arst   = 1'b1;
        vld    = '0;
        rdy_in = '0;
        for (int i = 0; i < 3; i++) trits[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset o_ready", o_rdy[i], 1);
            chk("reset o_valid", o_vld[i], 0);
            chk("reset o_value", o_val[i], 0);
            chk("reset o_err",   o_err[i], 0);
        end
        arst = 1'b0;
        @(posedge clk); #1;

        // TRITS_PER_CYCLE = 1
        send(0, 54'h0,                 64'sd0,              1'b0, 1'b0, 0);
        send(0, 54'h15_5555_5555_5555, 64'sd3812798742493, 1'b0, 1'b0, 0);
        send(0, 54'h3F_FFFF_FFFF_FFFF, -64'sd3812798742493, 1'b0, 1'b1, 0);
        send(0, 54'h1,                 64'sd1,              1'b0, 1'b0, 0);
        send(0, 54'h10_0000_0000_0000, 64'sd2541865828329, 1'b0, 1'b0, 0);
        send(0, 54'h800,               64'sd0,              1'b1, 1'b0, 0);
        send(0, 54'h7,                 64'sd2,              1'b0, 1'b0, 0);
        send(0, 54'h801,               64'sd1,              1'b1, 1'b0, 0);
        send(0, 54'h30,                -64'sd9,             1'b0, 1'b1, 0);
        abort_conv(0, 54'h15_5555_5555_5555);
        send(0, 54'h15_5555_5555_5555, 64'sd3812798742493, 1'b0, 1'b0, 0);
        send(0, 54'h30_0000_0000_0000, -64'sd2541865828329, 1'b0, 1'b0, 10);

        // TRITS_PER_CYCLE = 3
        send(1, 54'h10_0000_0000_0000, 64'sd2541865828329, 1'b0, 1'b0, 10);
        send(1, 54'h800,               64'sd0,              1'b1, 1'b0, 0);
        send(1, 54'h7,                 64'sd2,              1'b0, 1'b0, 0);

        // TRITS_PER_CYCLE = 27
        send(2, 54'h3F_FFFF_FFFF_FFFF, -64'sd3812798742493, 1'b0, 1'b0, 10);
        send(2, 54'h7,                 64'sd2,              1'b0, 1'b1, 0);
        send(2, 54'h801,               64'sd1,              1'b1, 1'b0, 0);

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 100) begin
            @(posedge clk);
            wait_cnt++;
        end
        chk("scoreboard drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
